// File: rtl/shift_sequencer_pkg.sv
// shiftpkg: command, slice-mode and sequencer-state types shared by the
// sequencer, its step counter and the mc10141 slice model.
package shiftpkg;

  // Commands accepted over the valid/ready handshake
  typedef enum logic [1:0] {
    CMD_LOAD  = 2'd0,
    CMD_TOLSB = 2'd1,
    CMD_TOMSB = 2'd2,
    CMD_NOP   = 2'd3
  } tShCmd;

  // {op2,op1} as seen by every mc10141 slice
  typedef enum logic [1:0] {
    LOAD   = 2'b00,
    SHIFTL = 2'b01,
    SHIFTR = 2'b10,
    HOLD   = 2'b11
  } tMode;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    SHIFTING,
    DONE
  } tSeqState;

  // Slice mode used to move the register in the commanded direction
  function automatic tMode shift_mode(input tShCmd op);
    return (op == CMD_TOMSB) ? SHIFTR : SHIFTL;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command handshake plus the slice-chain drive/feedback.
// master = requester / slice chain side, slave = sequencer.
interface shift_sequencer_if #(
  parameter int CNTW = 6
) ();
  import shiftpkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  tShCmd           cmd_op;
  logic [CNTW-1:0] cmd_count;
  logic            cmd_fill;
  logic            cmd_rot;
  logic            abort;
  logic            q_msb;
  logic            q_lsb;
  logic            op2;
  logic            op1;
  logic            shft0in;
  logic            shft3in;
  logic            busy;
  logic            done;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_rot, abort, q_msb, q_lsb,
    input  cmd_ready, op2, op1, shft0in, shft3in, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_rot, abort, q_msb, q_lsb,
    output cmd_ready, op2, op1, shft0in, shft3in, busy, done
  );

endinterface

// File: rtl/shift_sequencer_step_counter.sv
// shift_step_counter: loadable down-counter of remaining shift steps.
// last is high while exactly one step remains.
module shift_step_counter #(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            dec,
  input  logic [CNTW-1:0] din,
  output logic            last
);

  logic [CNTW-1:0] cnt;

  // Load takes priority; decrement once per shifting cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= din;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == CNTW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: runs one LOAD / shift / NOP command at a time on a chain
// of mc10141 4-bit slices by driving the shared mode lines and the two
// chain-end serial inputs.
// Optional feature macro: SHSEQ_ROTATE_EN (rotate through the chain ends).
module shift_sequencer
  import shiftpkg::*;
#(
  parameter int WIDTH = 36,
  parameter int CNTW  = 6
) (
  input logic              clk,
  input logic              rst,
  shift_sequencer_if.slave bus
);

  if (WIDTH % 4 != 0) begin : g_width_chk
    $error("shift_sequencer: WIDTH must be a multiple of 4");
  end

  tSeqState state, state_nx;
  tMode     mode_q, mode_nx;
  tShCmd    op_q, op_sel;
  logic     fill_q;
  logic     accept;
  logic     cnt_dec;
  logic     cnt_last;
  logic     sin0, sin3;

  assign accept = bus.cmd_valid && (state == IDLE);
  // Direction for the first shifting cycle comes straight from the bus
  assign op_sel = accept ? bus.cmd_op : op_q;

  shift_step_counter #(.CNTW(CNTW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (cnt_dec),
    .din  (bus.cmd_count),
    .last (cnt_last)
  );

  // State, latched command and registered mode lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= HOLD;
      op_q   <= CMD_NOP;
      fill_q <= 1'b0;
    end else begin
      state  <= state_nx;
      mode_q <= mode_nx;
      if (accept) begin
        op_q   <= bus.cmd_op;
        fill_q <= bus.cmd_fill;
      end
    end
  end

  // Next state, counter decrement and the mode to present next cycle
  always_comb begin
    state_nx = state;
    cnt_dec  = 1'b0;
    mode_nx  = HOLD;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            CMD_LOAD:             state_nx = LOADING;
            CMD_TOLSB, CMD_TOMSB: state_nx = (bus.cmd_count != '0) ? SHIFTING : DONE;
            default:              state_nx = DONE;
          endcase
        end
      end
      LOADING:  state_nx = DONE;
      SHIFTING: begin
        cnt_dec = 1'b1;
        if (bus.abort || cnt_last) state_nx = DONE;
      end
      default:  state_nx = IDLE;
    endcase
    case (state_nx)
      LOADING:  mode_nx = LOAD;
      SHIFTING: mode_nx = shift_mode(op_sel);
      default:  mode_nx = HOLD;
    endcase
  end

`ifdef SHSEQ_ROTATE_EN
  logic rot_q;

  // Rotate request is held for the whole command
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rot_q <= 1'b0;
    else if (accept) rot_q <= bus.cmd_rot;
  end

  // Rotating feeds the bit leaving the far end straight back in
  assign sin0 = rot_q ? bus.q_lsb : fill_q;
  assign sin3 = rot_q ? bus.q_msb : fill_q;
`else
  // Rotate request and chain feedback have no effect in this build
  logic unused_rot;
  assign unused_rot = ^{bus.cmd_rot, bus.q_msb, bus.q_lsb};

  assign sin0 = fill_q;
  assign sin3 = fill_q;
`endif

  // Only the end being shifted into sees data; the other end is held low
  assign bus.shft0in   = (mode_q == SHIFTL) && sin0;
  assign bus.shft3in   = (mode_q == SHIFTR) && sin3;
  assign bus.op2       = mode_q[1];
  assign bus.op1       = mode_q[0];
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule
